// File: rtl/drum_step_scheduler.sv
// Tempo-driven 8-step, 4-instrument drum scheduler: a BPM phase accumulator makes the
// eighth-note step ticks, and each step's hits go out one at a time over a req/ack voice port.
module drum_step_scheduler #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned THRESH = 30 * CLK_HZ,
    parameter int unsigned ACC_W  = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play,
    input  logic [7:0] bpm,
    input  logic [7:0] pat1,
    input  logic [7:0] pat2,
    input  logic [7:0] pat3,
    input  logic [7:0] pat4,
    input  logic       voice_ack,
    output logic [2:0] step,
    output logic       step_pulse,
    output logic       voice_req,
    output logic [1:0] voice_id,
    output logic       miss,
    output logic       busy
);

    localparam logic R_IDLE = 1'b0;
    localparam logic R_RUN  = 1'b1;
    localparam logic D_IDLE = 1'b0;
    localparam logic D_REQ  = 1'b1;

    localparam int unsigned    SUM_W    = ACC_W + 1;
    localparam logic [SUM_W-1:0] THRESH_V = SUM_W'(THRESH);

    logic             run_q, run_d;
    logic             dst_q, dst_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [2:0]       step_q, step_d;
    logic             pulse_q, pulse_d;
    logic [3:0]       pend_q, pend_d;
    logic             req_q, req_d;
    logic [1:0]       id_q, id_d;
    logic             miss_q, miss_d;

    logic [SUM_W-1:0] sum;
    logic             load, clear;
    logic [2:0]       load_step;
    logic [3:0]       col, grant, remain;

    always_comb begin
        sum       = {1'b0, acc_q} + SUM_W'(bpm);
        run_d     = run_q;
        acc_d     = acc_q;
        step_d    = step_q;
        pulse_d   = 1'b0;
        load      = 1'b0;
        clear     = 1'b0;
        load_step = 3'd0;
        case (run_q)
            R_IDLE: begin
                acc_d  = '0;
                step_d = '0;
                if (play) begin
                    run_d   = R_RUN;
                    pulse_d = 1'b1;
                    load    = 1'b1;
                end
            end
            default: begin
                if (!play) begin
                    run_d  = R_IDLE;
                    acc_d  = '0;
                    step_d = '0;
                    clear  = 1'b1;
                end else if (sum >= THRESH_V) begin
                    // Carry the remainder so the average step period stays exact.
                    acc_d     = ACC_W'(sum - THRESH_V);
                    step_d    = step_q + 3'd1;
                    pulse_d   = 1'b1;
                    load      = 1'b1;
                    load_step = step_q + 3'd1;
                end else begin
                    acc_d = ACC_W'(sum);
                end
            end
        endcase
        col = {pat4[load_step], pat3[load_step], pat2[load_step], pat1[load_step]};
    end

    always_comb begin
        dst_d = dst_q;
        req_d = req_q;
        id_d  = id_q;
        grant = '0;
        case (dst_q)
            D_IDLE: begin
                if (pend_q != 4'd0) begin
                    dst_d = D_REQ;
                    req_d = 1'b1;
                    if (pend_q[0]) begin
                        id_d = 2'd0; grant = 4'b0001;
                    end else if (pend_q[1]) begin
                        id_d = 2'd1; grant = 4'b0010;
                    end else if (pend_q[2]) begin
                        id_d = 2'd2; grant = 4'b0100;
                    end else begin
                        id_d = 2'd3; grant = 4'b1000;
                    end
                end
            end
            default: begin
                if (voice_ack) begin
                    req_d = 1'b0;
                    dst_d = D_IDLE;
                end
            end
        endcase

        // A dispatch from the old column still issues on a reload edge; only the rest is dropped.
        remain = pend_q & ~grant;
        miss_d = 1'b0;
        if (load) begin
            pend_d = col;
            miss_d = |remain;
        end else if (clear) begin
            pend_d = '0;
        end else begin
            pend_d = remain;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            run_q   <= R_IDLE;
            dst_q   <= D_IDLE;
            acc_q   <= '0;
            step_q  <= '0;
            pulse_q <= 1'b0;
            pend_q  <= '0;
            req_q   <= 1'b0;
            id_q    <= '0;
            miss_q  <= 1'b0;
        end else begin
            run_q   <= run_d;
            dst_q   <= dst_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
            req_q   <= req_d;
            id_q    <= id_d;
            miss_q  <= miss_d;
        end
    end

    assign step       = step_q;
    assign step_pulse = pulse_q;
    assign voice_req  = req_q;
    assign voice_id   = id_q;
    assign miss       = miss_q;
    assign busy       = req_q | (pend_q != 4'd0);

endmodule

// File: tb/tb_drum_step_scheduler.sv
// Bench for drum_step_scheduler at CLK_HZ=100 (THRESH=3000): tempo/pattern table with a
// request scoreboard, plus hand-written freeze, miss, stop and reset sequences.
module tb_drum_step_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       play;
    logic [7:0] bpm;
    logic [7:0] pat1, pat2, pat3, pat4;
    logic       voice_ack;
    logic [2:0] step;
    logic       step_pulse;
    logic       voice_req;
    logic [1:0] voice_id;
    logic       miss;
    logic       busy;

    always #5 clk = ~clk;

    drum_step_scheduler #(.CLK_HZ(100)) dut (
        .clk        (clk),
        .reset      (reset),
        .play       (play),
        .bpm        (bpm),
        .pat1       (pat1),
        .pat2       (pat2),
        .pat3       (pat3),
        .pat4       (pat4),
        .voice_ack  (voice_ack),
        .step       (step),
        .step_pulse (step_pulse),
        .voice_req  (voice_req),
        .voice_id   (voice_id),
        .miss       (miss),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0]  bpm;
        logic [7:0]  p1, p2, p3, p4;
        int unsigned gap_lo, gap_hi;
    } vec_t;

    vec_t        vecs[5];
    int          tests = 0;
    int          fails = 0;
    logic [1:0]  exp_q[$];
    logic        sb_en = 1'b0;
    logic        auto_ack = 1'b0;
    logic        prev_req = 1'b0;
    logic [2:0]  sb_step;
    int unsigned miss_seen;
    int unsigned cnt;
    int unsigned pulses;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int unsigned act,
                               input int unsigned lo, input int unsigned hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Scoreboard and ack responder, run once per cycle after the clock edge.
    task automatic mon();
        logic [3:0] col;
        if (sb_en) begin
            if (voice_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected_req: got id %0d, required no request", voice_id);
                end else begin
                    check("sb_req_id", 32'(voice_id), 32'(exp_q.pop_front()));
                end
            end
            if (step_pulse) begin
                col = {pat4[sb_step], pat3[sb_step], pat2[sb_step], pat1[sb_step]};
                for (int i = 0; i < 4; i++)
                    if (col[i]) exp_q.push_back(2'(i));
                sb_step = sb_step + 3'd1;
            end
            if (miss) miss_seen++;
        end
        if (voice_ack) voice_ack = 1'b0;
        else if (auto_ack && voice_req && prev_req) voice_ack = 1'b1;
        prev_req = voice_req;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mon();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        play  = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        vecs[0] = '{bpm: 8'd250, p1: 8'h00, p2: 8'h00, p3: 8'h00, p4: 8'h00, gap_lo: 12, gap_hi: 12};
        vecs[1] = '{bpm: 8'd250, p1: 8'h01, p2: 8'h00, p3: 8'h01, p4: 8'h00, gap_lo: 12, gap_hi: 12};
        vecs[2] = '{bpm: 8'd100, p1: 8'h01, p2: 8'h22, p3: 8'h05, p4: 8'h90, gap_lo: 30, gap_hi: 30};
        vecs[3] = '{bpm: 8'd255, p1: 8'hAA, p2: 8'h55, p3: 8'h00, p4: 8'h00, gap_lo: 11, gap_hi: 12};
        vecs[4] = '{bpm: 8'd200, p1: 8'h0F, p2: 8'hF0, p3: 8'h3C, p4: 8'hC3, gap_lo: 15, gap_hi: 15};

        reset = 1'b0; play = 1'b0; bpm = 8'd0; voice_ack = 1'b0;
        pat1 = '0; pat2 = '0; pat3 = '0; pat4 = '0;
        do_reset();
        check("rst_step", 32'(step), 0);
        check("rst_step_pulse", 32'(step_pulse), 0);
        check("rst_voice_req", 32'(voice_req), 0);
        check("rst_voice_id", 32'(voice_id), 0);
        check("rst_miss", 32'(miss), 0);
        check("rst_busy", 32'(busy), 0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            bpm = vecs[v].bpm;
            pat1 = vecs[v].p1; pat2 = vecs[v].p2; pat3 = vecs[v].p3; pat4 = vecs[v].p4;
            exp_q.delete();
            sb_step = 3'd0;
            miss_seen = 0;
            sb_en = 1'b1;
            auto_ack = 1'b1;
            play = 1'b1;
            for (int p = 0; p < 9; p++) begin
                cnt = 0;
                do begin
                    tick();
                    cnt++;
                end while (!step_pulse && cnt < 40);
                check("pulse_seen", 32'(step_pulse), 1);
                check("step_seq", 32'(step), 32'(p % 8));
                if (p == 0) check("first_pulse_latency", cnt, 1);
                else check_range("tick_gap", cnt, vecs[v].gap_lo, vecs[v].gap_hi);
            end
            repeat (10) tick();
            check("sb_drained", 32'(exp_q.size()), 0);
            check("no_miss", miss_seen, 0);
            check("busy_idle", 32'(busy), 0);
            sb_en = 1'b0;
            auto_ack = 1'b0;
            play = 1'b0;
        end

        // Tempo freeze with bpm=0 and resume from the stored accumulator.
        do_reset();
        pat1 = '0; pat2 = '0; pat3 = '0; pat4 = '0;
        bpm = 8'd100;
        play = 1'b1;
        tick();
        check("frz_start_pulse", 32'(step_pulse), 1);
        repeat (10) tick();
        bpm = 8'd0;
        pulses = 0;
        repeat (50) begin
            tick();
            if (step_pulse) pulses++;
        end
        check("frz_no_pulse", pulses, 0);
        check("frz_step", 32'(step), 0);
        bpm = 8'd100;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!step_pulse && cnt < 40);
        check("frz_resume_latency", cnt, 20);
        check("frz_resume_step", 32'(step), 1);

        // All hits, ack withheld: miss at the next tick, request 0 stays held.
        do_reset();
        pat1 = 8'hFF; pat2 = 8'hFF; pat3 = 8'hFF; pat4 = 8'hFF;
        bpm = 8'd250;
        play = 1'b1;
        tick();
        check("ff_pulse0", 32'(step_pulse), 1);
        check("ff_busy0", 32'(busy), 1);
        check("ff_req0_low", 32'(voice_req), 0);
        tick();
        check("ff_req_rise", 32'(voice_req), 1);
        check("ff_req_id", 32'(voice_id), 0);
        repeat (10) tick();
        check("ff_premiss", 32'(miss), 0);
        check("ff_prepulse", 32'(step_pulse), 0);
        tick();
        check("ff_tick_pulse", 32'(step_pulse), 1);
        check("ff_tick_step", 32'(step), 1);
        check("ff_miss", 32'(miss), 1);
        check("ff_req_held", 32'(voice_req), 1);
        check("ff_id_held", 32'(voice_id), 0);
        tick();
        check("ff_miss_single", 32'(miss), 0);
        check("ff_req_still", 32'(voice_req), 1);
        check("ff_busy", 32'(busy), 1);

        // Stop during a request: step clears, request held until ack, nothing after.
        play = 1'b0;
        tick();
        check("stop_step", 32'(step), 0);
        check("stop_req_held", 32'(voice_req), 1);
        check("stop_no_pulse", 32'(step_pulse), 0);
        voice_ack = 1'b1;
        tick();
        check("stop_req_drop", 32'(voice_req), 0);
        check("stop_busy", 32'(busy), 0);
        pulses = 0;
        repeat (10) begin
            tick();
            if (voice_req || step_pulse) pulses++;
        end
        check("stop_quiet", pulses, 0);
        play = 1'b1;
        tick();
        check("restart_pulse", 32'(step_pulse), 1);
        check("restart_step", 32'(step), 0);
        tick();
        check("restart_req", 32'(voice_req), 1);
        check("restart_id", 32'(voice_id), 0);

        // Reset while running with a request in flight.
        reset = 1'b0;
        tick();
        check("rrun_step", 32'(step), 0);
        check("rrun_pulse", 32'(step_pulse), 0);
        check("rrun_req", 32'(voice_req), 0);
        check("rrun_id", 32'(voice_id), 0);
        check("rrun_miss", 32'(miss), 0);
        check("rrun_busy", 32'(busy), 0);
        play = 1'b0;
        reset = 1'b1;
        pulses = 0;
        repeat (5) begin
            tick();
            if (step_pulse || voice_req) pulses++;
        end
        check("rrun_idle", pulses, 0);
        check("rrun_idle_step", 32'(step), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
